// File: rtl/gps_ack_pkg.sv
// Shared types for the gps_ack peak tracker: result record layout and tracker FSM states.
package gps_ack_pkg;

  localparam int unsigned NumCh = 8;
  localparam int unsigned SatW  = 6;
  localparam int unsigned IntW  = 12;
  localparam int unsigned CpW   = 10;
  localparam int unsigned DopW  = 16;

  typedef struct packed {
    logic [SatW-1:0]        sat;
    logic [IntW-1:0]        peak;
    logic [IntW-1:0]        second;
    logic [CpW-1:0]         code_phase;
    logic signed [DopW-1:0] doppler;
  } ack_result_t;

  typedef enum logic [0:0] {StAccum, StReport} trk_state_e;

endpackage

// File: rtl/gps_ack_peak_ch.sv
// One correlator channel's peak record: best / second-best magnitude and the bin of the best.
module gps_ack_peak_ch #(
  parameter int unsigned SAT_W = 6,
  parameter int unsigned INT_W = 12,
  parameter int unsigned CP_W  = 10,
  parameter int unsigned DOP_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    upd,
  input  logic [SAT_W-1:0]        sat_in,
  input  logic [INT_W-1:0]        integ,
  input  logic [CP_W-1:0]         code_phase,
  input  logic signed [DOP_W-1:0] doppler,
  output logic [SAT_W-1:0]        rec_sat,
  output logic [INT_W-1:0]        rec_peak,
  output logic [INT_W-1:0]        rec_second,
  output logic [CP_W-1:0]         rec_cp,
  output logic signed [DOP_W-1:0] rec_dop
);

  logic [SAT_W-1:0]        sat_q, sat_d;
  logic [INT_W-1:0]        peak_q, peak_d;
  logic [INT_W-1:0]        second_q, second_d;
  logic [CP_W-1:0]         cp_q, cp_d;
  logic signed [DOP_W-1:0] dop_q, dop_d;

  always_comb begin
    sat_d    = sat_q;
    peak_d   = peak_q;
    second_d = second_q;
    cp_d     = cp_q;
    dop_d    = dop_q;
    if (clear) begin
      sat_d    = '0;
      peak_d   = '0;
      second_d = '0;
      cp_d     = '0;
      dop_d    = '0;
    end else if (upd) begin
      if (sat_in != sat_q) begin
        // New satellite on this channel: previous history is meaningless.
        sat_d    = sat_in;
        peak_d   = integ;
        second_d = '0;
        cp_d     = code_phase;
        dop_d    = doppler;
      end else if (integ > peak_q) begin
        second_d = peak_q;
        peak_d   = integ;
        cp_d     = code_phase;
        dop_d    = doppler;
      end else if (integ > second_q) begin
        second_d = integ;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_q    <= '0;
      peak_q   <= '0;
      second_q <= '0;
      cp_q     <= '0;
      dop_q    <= '0;
    end else begin
      sat_q    <= sat_d;
      peak_q   <= peak_d;
      second_q <= second_d;
      cp_q     <= cp_d;
      dop_q    <= dop_d;
    end
  end

  assign rec_sat    = sat_q;
  assign rec_peak   = peak_q;
  assign rec_second = second_q;
  assign rec_cp     = cp_q;
  assign rec_dop    = dop_q;

endmodule

// File: rtl/gps_ack_peak_tracker.sv
// Post-correlation peak tracker: per-channel peak records, streamed out over valid/ready
// once a search completes.
module gps_ack_peak_tracker
  import gps_ack_pkg::*;
#(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned SAT_W  = 6,
  parameter int unsigned INT_W  = 12,
  parameter int unsigned CP_W   = 10,
  parameter int unsigned DOP_W  = 16,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    corr_valid,
  input  logic [NUM_CH*SAT_W-1:0] sat_flat,
  input  logic [NUM_CH*INT_W-1:0] integ_flat,
  input  logic [CP_W-1:0]         code_phase,
  input  logic signed [DOP_W-1:0] doppler_omega,
  input  logic                    search_complete,
  input  logic [INT_W-1:0]        threshold,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [CH_W-1:0]         res_ch,
  output logic [SAT_W-1:0]        res_sat,
  output logic [INT_W-1:0]        res_peak,
  output logic [INT_W-1:0]        res_second,
  output logic [CP_W-1:0]         res_code_phase,
  output logic signed [DOP_W-1:0] res_doppler,
  output logic                    res_detected,
  output logic                    res_last,
  output logic                    busy,
  output logic                    report_done
);

  trk_state_e      state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic            done_q, done_d;
  logic            upd;
  logic            is_last;

  logic [SAT_W-1:0]        ch_sat    [NUM_CH];
  logic [INT_W-1:0]        ch_peak   [NUM_CH];
  logic [INT_W-1:0]        ch_second [NUM_CH];
  logic [CP_W-1:0]         ch_cp     [NUM_CH];
  logic signed [DOP_W-1:0] ch_dop    [NUM_CH];

  // Records are frozen while reporting; clear overrides any update.
  assign upd = corr_valid && (state_q == StAccum) && !clear;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    gps_ack_peak_ch #(
      .SAT_W (SAT_W),
      .INT_W (INT_W),
      .CP_W  (CP_W),
      .DOP_W (DOP_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .upd        (upd),
      .sat_in     (sat_flat[g*SAT_W +: SAT_W]),
      .integ      (integ_flat[g*INT_W +: INT_W]),
      .code_phase (code_phase),
      .doppler    (doppler_omega),
      .rec_sat    (ch_sat[g]),
      .rec_peak   (ch_peak[g]),
      .rec_second (ch_second[g]),
      .rec_cp     (ch_cp[g]),
      .rec_dop    (ch_dop[g])
    );
  end

  assign is_last = (ch_q == CH_W'(NUM_CH - 1));

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    done_d  = 1'b0;
    if (clear) begin
      state_d = StAccum;
      ch_d    = '0;
    end else begin
      unique case (state_q)
        StAccum: begin
          if (search_complete) begin
            state_d = StReport;
            ch_d    = '0;
          end
        end
        StReport: begin
          if (res_ready) begin
            if (is_last) begin
              state_d = StAccum;
              ch_d    = '0;
              done_d  = 1'b1;
            end else begin
              ch_d = ch_q + CH_W'(1);
            end
          end
        end
        default: state_d = StAccum;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StAccum;
      ch_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      done_q  <= done_d;
    end
  end

  assign res_valid      = (state_q == StReport);
  assign busy           = (state_q == StReport);
  assign report_done    = done_q;
  assign res_ch         = ch_q;
  assign res_sat        = ch_sat[ch_q];
  assign res_peak       = ch_peak[ch_q];
  assign res_second     = ch_second[ch_q];
  assign res_code_phase = ch_cp[ch_q];
  assign res_doppler    = ch_dop[ch_q];
  assign res_last       = res_valid && is_last;
  assign res_detected   = (res_peak >= threshold) && (res_peak != '0);

endmodule
